// File: rtl/ppu_vram_arbiter.sv
// Arbitrates the PPU VRAM/CHR bus between the render fetch engine and the
// CPU-side PPUDATA port, with a one-entry pending slot and a starvation guard.
module ppu_vram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_active,
  input  logic              rnd_req,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic              rnd_gnt,
  output logic [7:0]        rnd_rdata,
  output logic              rnd_valid,
  input  logic              ri_rd_req,
  input  logic              ri_wr_req,
  input  logic [ADDR_W-1:0] ri_addr,
  input  logic [7:0]        ri_wdata,
  output logic [7:0]        ri_rdata,
  output logic              ri_done,
  output logic              ri_busy,
  output logic              ri_overrun,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              r_slot_full;
  logic              r_slot_rw;
  logic [ADDR_W-1:0] r_slot_addr;
  logic [7:0]        r_slot_wdata;
  logic [SW-1:0]     r_starve;
  logic              r_overrun;

  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  // Owner tags: stage k holds the op issued k+1 cycles after its grant.
  logic [RD_LAT:0]   r_tag_vld;
  logic [RD_LAT:0]   r_tag_ri;
  logic [RD_LAT:0]   r_tag_rw;

  logic              r_rnd_valid;
  logic [7:0]        r_rnd_rdata;
  logic              r_ri_done;
  logic [7:0]        r_ri_rdata;

  logic              w_rnd_req;
  logic              w_force;
  logic              w_rnd_gnt;
  logic              w_slot_gnt;
  logic              w_new_req;
  logic              w_rd_cap;
  logic              w_wr_done;

  assign w_rnd_req  = render_active & rnd_req & ~rst;
  assign w_force    = r_slot_full && (r_starve == SW'(STARVE_MAX));
  assign w_rnd_gnt  = w_rnd_req & ~w_force;
  assign w_slot_gnt = r_slot_full & ~w_rnd_gnt;
  assign w_new_req  = ri_rd_req | ri_wr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_full  <= 1'b0;
      r_slot_rw    <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_wdata <= '0;
      r_starve     <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_new_req & r_slot_full & ~w_slot_gnt;
      if (w_new_req) begin
        // Write wins when both pulses coincide.
        r_slot_full  <= 1'b1;
        r_slot_rw    <= ri_wr_req;
        r_slot_addr  <= ri_addr;
        r_slot_wdata <= ri_wdata;
      end else if (w_slot_gnt) begin
        r_slot_full <= 1'b0;
      end
      if (!r_slot_full || w_slot_gnt)
        r_starve <= '0;
      else if (r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_re <= w_rnd_gnt | (w_slot_gnt & ~r_slot_rw);
      r_mem_we <= w_slot_gnt & r_slot_rw;
      if (w_rnd_gnt) begin
        r_mem_addr <= rnd_addr;
      end else if (w_slot_gnt) begin
        r_mem_addr  <= r_slot_addr;
        r_mem_wdata <= r_slot_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_ri  <= '0;
      r_tag_rw  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_rnd_gnt | w_slot_gnt};
      r_tag_ri  <= {r_tag_ri[RD_LAT-1:0],  w_slot_gnt};
      r_tag_rw  <= {r_tag_rw[RD_LAT-1:0],  w_slot_gnt & r_slot_rw};
    end
  end

  // Reads retire from the last tag stage; writes retire right after issue.
  assign w_rd_cap  = r_tag_vld[RD_LAT] & ~r_tag_rw[RD_LAT];
  assign w_wr_done = r_tag_vld[0] & r_tag_ri[0] & r_tag_rw[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd_valid <= 1'b0;
      r_rnd_rdata <= '0;
      r_ri_done   <= 1'b0;
      r_ri_rdata  <= '0;
    end else begin
      r_rnd_valid <= w_rd_cap & ~r_tag_ri[RD_LAT];
      r_ri_done   <= (w_rd_cap & r_tag_ri[RD_LAT]) | w_wr_done;
      if (w_rd_cap && !r_tag_ri[RD_LAT])
        r_rnd_rdata <= mem_rdata;
      if (w_rd_cap && r_tag_ri[RD_LAT])
        r_ri_rdata <= mem_rdata;
    end
  end

  assign rnd_gnt    = w_rnd_gnt;
  assign rnd_rdata  = r_rnd_rdata;
  assign rnd_valid  = r_rnd_valid;
  assign ri_rdata   = r_ri_rdata;
  assign ri_done    = r_ri_done;
  assign ri_busy    = r_slot_full;
  assign ri_overrun = r_overrun;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;

endmodule
